// File: rtl/scroller_pkg.sv
// Shared constants for the skyline scrollers: LFSR step, cutoff ceiling and palette.
// Pure definitions, no logic; no latency, no backpressure.
package scroller_pkg;

    localparam int              LFSR_W      = 9;
    localparam int              LFSR_TAP_HI = 8;
    localparam int              LFSR_TAP_LO = 4;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 9'h1FF;

    localparam logic [4:0]      CUTOFF_MAX  = 5'd16;

    // Index 0 is sky; then far/dark to near/bright. The nearest layer always takes PALETTE_NEAREST.
    localparam int              PALETTE_LEN = 9;
    localparam logic [5:0]      PALETTE [PALETTE_LEN] = '{
        6'b01_10_11, 6'b00_01_01, 6'b01_01_00, 6'b10_01_00, 6'b11_10_00,
        6'b11_10_01, 6'b11_11_00, 6'b11_11_01, 6'b11_11_10
    };
    localparam logic [5:0]      PALETTE_NEAREST = 6'b11_10_00;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

    function automatic logic [5:0] palette_color(input int idx, input int n_layers);
        logic [5:0] c;
        c = PALETTE[idx];
        if (idx != 0 && idx == n_layers) c = PALETTE_NEAREST;
        return c;
    endfunction

endpackage

// File: rtl/parallax_layer.sv
// One skyline layer: frame/line column LFSRs, column counters and height-ramp cutoff.
// solid is combinational from registered state; no backpressure (free-running with the raster).
module parallax_layer
    import scroller_pkg::*;
#(
    parameter int LAYER_IDX  = 0,
    parameter int COL_SHIFT  = 3,
    parameter int STEP_SHIFT = 4,
    parameter int HORIZON    = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] vcount,
    input  logic       visible,
    input  logic       line_start,
    input  logic       frame_start,
    input  logic       scroll_en,
    output logic       solid
);

    localparam logic [9:0]           HZ      = 10'(HORIZON);
    localparam logic [COL_SHIFT:0]   INC     = (COL_SHIFT+1)'(LAYER_IDX + 1);
    localparam logic [COL_SHIFT-1:0] CNT_ONE = COL_SHIFT'(1);

    logic [LFSR_W-1:0]    r_frame_lfsr;
    logic [COL_SHIFT-1:0] r_frame_cnt;
    logic [LFSR_W-1:0]    r_line_lfsr;
    logic [COL_SHIFT-1:0] r_line_cnt;
    logic [4:0]           r_cutoff;

    logic [COL_SHIFT:0]    w_frame_sum;
    logic [STEP_SHIFT-1:0] w_phase;
    logic                  w_ramp;

    assign w_frame_sum = {1'b0, r_frame_cnt} + INC;
    // Only the low bits of (vcount - horizon) matter for the ramp-step test.
    assign w_phase     = vcount[STEP_SHIFT-1:0] - HZ[STEP_SHIFT-1:0];
    assign w_ramp      = (vcount > HZ) && (w_phase == '0) && (r_cutoff < CUTOFF_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_lfsr <= LFSR_SEED;
            r_frame_cnt  <= '1;
            r_line_lfsr  <= LFSR_SEED;
            r_line_cnt   <= '1;
            r_cutoff     <= '0;
        end else begin
            if (frame_start && scroll_en) begin
                r_frame_cnt <= w_frame_sum[COL_SHIFT-1:0];
                if (w_frame_sum[COL_SHIFT]) r_frame_lfsr <= lfsr_next(r_frame_lfsr);
            end

            if (line_start) begin
                r_line_lfsr <= r_frame_lfsr;
                r_line_cnt  <= r_frame_cnt;
            end else if (visible) begin
                r_line_cnt <= r_line_cnt + CNT_ONE;
                if (r_line_cnt == '0) r_line_lfsr <= lfsr_next(r_line_lfsr);
            end

            if (frame_start) begin
                r_cutoff <= '0;
            end else if (line_start) begin
                if (vcount == HZ)  r_cutoff <= 5'd1;
                else if (w_ramp)   r_cutoff <= r_cutoff + 5'd1;
            end
        end
    end

    assign solid = ({1'b0, r_line_lfsr[3:0]} < r_cutoff);

endmodule

// File: rtl/parallax_layer_engine.sv
// N-layer parallax skyline: per-layer solid flags, nearest-wins priority, palette, output regs.
// One-cycle registered latency from raster inputs to rgb_out/layer_out; no backpressure.
module parallax_layer_engine
    import scroller_pkg::*;
#(
    parameter int N_LAYERS     = 4,
    parameter int COL_SHIFT    = 3,
    parameter int STEP_SHIFT   = 4,
    parameter int HORIZON_BASE = 128,
    parameter int HORIZON_STEP = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [9:0]                        hcount,
    input  logic [9:0]                        vcount,
    input  logic                              visible,
    input  logic                              line_start,
    input  logic                              frame_start,
    input  logic                              scroll_en,
    output logic [5:0]                        rgb_out,
    output logic [$clog2(N_LAYERS+1)-1:0]     layer_out
);

    localparam int LW = $clog2(N_LAYERS + 1);

    logic [N_LAYERS-1:0] w_solid;
    logic [LW-1:0]       w_win;
    logic [5:0]          w_rgb;
    logic                w_unused_hcount;
    logic [5:0]          r_rgb;
    logic [LW-1:0]       r_layer;

    // Column position comes from the per-layer counters, so the raster column is not needed.
    assign w_unused_hcount = ^hcount;

    for (genvar l = 0; l < N_LAYERS; l++) begin : g_layer
        parallax_layer #(
            .LAYER_IDX  (l),
            .COL_SHIFT  (COL_SHIFT),
            .STEP_SHIFT (STEP_SHIFT),
            .HORIZON    (HORIZON_BASE + l * HORIZON_STEP)
        ) u_layer (
            .clk         (clk),
            .rst         (rst),
            .vcount      (vcount),
            .visible     (visible),
            .line_start  (line_start),
            .frame_start (frame_start),
            .scroll_en   (scroll_en),
            .solid       (w_solid[l])
        );
    end

    // Ascending scan: the last (nearest) solid layer overwrites any farther one.
    always_comb begin
        w_win = '0;
        for (int l = 0; l < N_LAYERS; l++) begin
            if (w_solid[l]) w_win = LW'(l + 1);
        end
    end

    assign w_rgb = palette_color(int'(w_win), N_LAYERS);

    always_ff @(posedge clk) begin
        if (rst || !visible) begin
            r_rgb   <= '0;
            r_layer <= '0;
        end else begin
            r_rgb   <= w_rgb;
            r_layer <= w_win;
        end
    end

    assign rgb_out   = r_rgb;
    assign layer_out = r_layer;

endmodule
